fetch_buffer: RTL

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction fetch unit feeding a 2-entry {pc, instr} buffer.
// One instruction-memory request may be outstanding. A branch flush clears
// the buffer and redirects fetch. A request that is still outstanding when
// the flush arrives is completed and its data discarded.
// Optional build macro FETCH_ALIGN_CHECK_EN: a redirect to a target that is
// not word aligned sets the sticky misalign_err flag and halts fetching.
// Without the macro, the low two target bits are forced to zero.
//
// Handshakes:
// - imem_req/imem_ack: imem_req stays high with a stable imem_addr until a
//   cycle with imem_ack=1, which completes the transfer. imem_rdata is valid
//   in that same cycle. An ack while imem_req=0 has no effect.
// - instr_valid/instr_ready: the head entry transfers to decode in any cycle
//   where both are high. Once instr_valid is high it stays high until the
//   entry is taken or a flush occurs.
module fetch_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_data,
    output logic        misalign_err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] pc_mem_q [2];
    logic [31:0] pc_mem_d [2];
    logic [31:0] data_mem_q [2];
    logic [31:0] data_mem_d [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        misalign_q, misalign_d;

    logic [31:0] target_pc;
    logic        bad_target;
    logic        halt_next;
    logic        push;
    logic        pop;
    logic        wr_idx;
    logic [1:0]  cnt_after;

`ifdef FETCH_ALIGN_CHECK_EN
    assign target_pc    = branch_target;
    assign bad_target   = branch_taken && (branch_target[1:0] != 2'b00);
    assign misalign_err = misalign_q;
`else
    assign target_pc    = branch_target & 32'hFFFF_FFFC;
    assign bad_target   = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // A misaligned redirect halts fetching from the flush cycle onward.
    assign halt_next = misalign_q | bad_target;

    assign imem_req    = (state_q != S_IDLE);
    assign imem_addr   = addr_q;
    assign instr_valid = (count_q != 2'd0);
    assign instr_pc    = pc_mem_q[rd_ptr_q];
    assign instr_data  = data_mem_q[rd_ptr_q];
    assign dbg_state   = state_q;

    // Write slot is head + count (mod 2). When the buffer is full, this is the
    // head slot, which the same-cycle pop frees.
    assign pop       = instr_valid && instr_ready;
    assign push      = (state_q == S_WAIT) && imem_ack && !branch_taken;
    assign wr_idx    = rd_ptr_q ^ count_q[0];
    assign cnt_after = count_q + {1'b0, push} - {1'b0, pop};

    // Buffer update, fetch-PC tracking and next-state selection.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pc_mem_d   = pc_mem_q;
        data_mem_d = data_mem_q;
        misalign_d = misalign_q;

        if (branch_taken) begin
            count_d    = 2'd0;
            rd_ptr_d   = 1'b0;
            fetch_pc_d = target_pc;
            misalign_d = misalign_q | bad_target;
        end else begin
            if (push) begin
                pc_mem_d[wr_idx]   = addr_q;
                data_mem_d[wr_idx] = imem_rdata;
                fetch_pc_d         = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = cnt_after;
        end

        case (state_q)
            S_IDLE: begin
                if (branch_taken) begin
                    if (!halt_next) begin
                        state_d = S_WAIT;
                        addr_d  = target_pc;
                    end
                end else if (!misalign_q && (count_q < 2'd2)) begin
                    state_d = S_WAIT;
                    addr_d  = fetch_pc_q;
                end
            end
            S_WAIT: begin
                if (branch_taken) begin
                    if (!imem_ack) begin
                        state_d = S_DROP;
                    end else if (halt_next) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                        addr_d  = target_pc;
                    end
                end else if (imem_ack) begin
                    if ((cnt_after < 2'd2) && !misalign_q) begin
                        state_d = S_WAIT;
                        addr_d  = fetch_pc_q + 32'd4;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    if (branch_taken && !halt_next) begin
                        state_d = S_WAIT;
                        addr_d  = target_pc;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            fetch_pc_q    <= RESET_PC;
            addr_q        <= RESET_PC;
            pc_mem_q[0]   <= '0;
            pc_mem_q[1]   <= '0;
            data_mem_q[0] <= '0;
            data_mem_q[1] <= '0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            misalign_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            pc_mem_q   <= pc_mem_d;
            data_mem_q <= data_mem_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

endmodule
